// File: rtl/control_unit.sv
// Main opcode decoder for the RV64 single-cycle core.
// Control word is decoded combinationally and registered once per clock.
module control_unit #(
  parameter bit ENABLE_ITYPE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_to_reg,
  output logic [1:0] alu_op,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic       illegal
);

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 2;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_BRANCH = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_RTYPE  = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_ITYPE  = 2'b11;

  typedef struct packed {
    logic                branch;
    logic                mem_read;
    logic                mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_write;
    logic                alu_src;
    logic                reg_write;
    logic                illegal;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Anything not explicitly matched falls back to the inert illegal word.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.alu_op  = ALU_ADD;
    ctrl_d.illegal = 1'b1;
    case (opcode)
      OP_LOAD: begin
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.illegal    = 1'b0;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.illegal   = 1'b0;
      end
      OP_BRANCH: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_op  = ALU_BRANCH;
        ctrl_d.illegal = 1'b0;
      end
      OP_RTYPE: begin
        ctrl_d.alu_op    = ALU_RTYPE;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.illegal   = 1'b0;
      end
      OP_ITYPE: begin
        if (ENABLE_ITYPE) begin
          ctrl_d.alu_op    = ALU_ITYPE;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.illegal   = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Synchronous reset clears the whole word, including illegal.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign branch     = ctrl_q.branch;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_op     = ctrl_q.alu_op;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_write  = ctrl_q.reg_write;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: two instances (I-type enabled / disabled)
// driven in lockstep, expected words queued at drive time and popped after the edge.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;

  logic       branch1, mem_read1, mem_to_reg1, mem_write1, alu_src1, reg_write1, illegal1;
  logic [1:0] alu_op1;
  logic       branch0, mem_read0, mem_to_reg0, mem_write0, alu_src0, reg_write0, illegal0;
  logic [1:0] alu_op0;

  control_unit #(.ENABLE_ITYPE(1'b1)) u_dut_en (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch(branch1), .mem_read(mem_read1), .mem_to_reg(mem_to_reg1), .alu_op(alu_op1),
    .mem_write(mem_write1), .alu_src(alu_src1), .reg_write(reg_write1), .illegal(illegal1)
  );

  control_unit #(.ENABLE_ITYPE(1'b0)) u_dut_dis (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch(branch0), .mem_read(mem_read0), .mem_to_reg(mem_to_reg0), .alu_op(alu_op0),
    .mem_write(mem_write0), .alu_src(alu_src0), .reg_write(reg_write0), .illegal(illegal0)
  );

  // Word order: branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write, illegal
  localparam logic [8:0] W_LD  = 9'b0_1_1_00_0_1_1_0;
  localparam logic [8:0] W_SD  = 9'b0_0_0_00_1_1_0_0;
  localparam logic [8:0] W_BEQ = 9'b1_0_0_01_0_0_0_0;
  localparam logic [8:0] W_R   = 9'b0_0_0_10_0_0_1_0;
  localparam logic [8:0] W_I   = 9'b0_0_0_11_0_1_1_0;
  localparam logic [8:0] W_ILL = 9'b0_0_0_00_0_0_0_1;
  localparam logic [8:0] W_RST = 9'b0_0_0_00_0_0_0_0;

  typedef struct {
    logic       rst_n;
    logic [6:0] op;
    logic [8:0] exp_en;
    logic [8:0] exp_dis;
  } vec_t;

  logic [8:0] exp_q_en[$];
  logic [8:0] exp_q_dis[$];
  int checks;
  int passes;
  int fails;

  wire [8:0] out_en  = {branch1, mem_read1, mem_to_reg1, alu_op1, mem_write1, alu_src1, reg_write1, illegal1};
  wire [8:0] out_dis = {branch0, mem_read0, mem_to_reg0, alu_op0, mem_write0, alu_src0, reg_write0, illegal0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Independent reference decode written from the opcode table.
  function automatic logic [8:0] ref_word(input logic [6:0] op, input bit en_itype);
    logic [8:0] w;
    w = W_ILL;
    if (op == 7'b0000011) w = W_LD;
    if (op == 7'b0100011) w = W_SD;
    if (op == 7'b1100011) w = W_BEQ;
    if (op == 7'b0110011) w = W_R;
    if (op == 7'b0010011 && en_itype) w = W_I;
    return w;
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end else begin
      passes++;
    end
  endtask

  // Drive one cycle, queue the expectation, and compare once the edge has loaded it.
  task automatic cycle(input string name, input logic r, input logic [6:0] op,
                       input logic [8:0] e_en, input logic [8:0] e_dis);
    logic [8:0] e;
    rst_n  = r;
    opcode = op;
    exp_q_en.push_back(e_en);
    exp_q_dis.push_back(e_dis);
    @(posedge clk);
    #1;
    if (exp_q_en.size() == 0 || exp_q_dis.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: scoreboard empty, got no entry required one", name);
    end else begin
      e = exp_q_en.pop_front();
      check({name, "/en"}, out_en, e);
      e = exp_q_dis.pop_front();
      check({name, "/dis"}, out_dis, e);
    end
  endtask

  vec_t vecs[$];
  int legal_en;
  int legal_dis;

  initial begin
    checks = 0; passes = 0; fails = 0;
    rst_n  = 1'b0;
    opcode = 7'b0000011;

    vecs.push_back('{1'b0, 7'b0000011, W_RST, W_RST});
    vecs.push_back('{1'b0, 7'b0000011, W_RST, W_RST});
    vecs.push_back('{1'b1, 7'b0000011, W_LD,  W_LD});
    vecs.push_back('{1'b1, 7'b0100011, W_SD,  W_SD});
    vecs.push_back('{1'b1, 7'b1100011, W_BEQ, W_BEQ});
    vecs.push_back('{1'b1, 7'b0110011, W_R,   W_R});
    vecs.push_back('{1'b1, 7'b0010011, W_I,   W_ILL});
    vecs.push_back('{1'b1, 7'b1111111, W_ILL, W_ILL});
    vecs.push_back('{1'b1, 7'b0000000, W_ILL, W_ILL});
    vecs.push_back('{1'b1, 7'b0110111, W_ILL, W_ILL});
    vecs.push_back('{1'b1, 7'b0000001, W_ILL, W_ILL});
    vecs.push_back('{1'b1, 7'b1100010, W_ILL, W_ILL});
    vecs.push_back('{1'b1, 7'b0010011, W_I,   W_ILL});
    vecs.push_back('{1'b1, 7'b0000011, W_LD,  W_LD});
    // Mid-stream reset: store, reset edge, then R-type resumes without a bubble.
    vecs.push_back('{1'b1, 7'b0100011, W_SD,  W_SD});
    vecs.push_back('{1'b0, 7'b0100011, W_RST, W_RST});
    vecs.push_back('{1'b1, 7'b0110011, W_R,   W_R});
    // Reset overrides an illegal opcode too.
    vecs.push_back('{1'b1, 7'b1111111, W_ILL, W_ILL});
    vecs.push_back('{1'b0, 7'b1111111, W_RST, W_RST});

    foreach (vecs[i]) begin
      cycle($sformatf("vec%0d_op%b_rst%b", i, vecs[i].op, vecs[i].rst_n),
            vecs[i].rst_n, vecs[i].op, vecs[i].exp_en, vecs[i].exp_dis);
    end

    // A reset pulse between edges must not disturb the held outputs.
    cycle("glitch_setup", 1'b1, 7'b1100011, W_BEQ, W_BEQ);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("glitch_hold/en", out_en, W_BEQ);
    check("glitch_hold/dis", out_dis, W_BEQ);
    cycle("glitch_next_edge", 1'b1, 7'b1100011, W_BEQ, W_BEQ);

    // Exhaustive sweep with invariant checks.
    legal_en  = 0;
    legal_dis = 0;
    for (int op = 0; op < 128; op++) begin
      cycle($sformatf("sweep_%b", 7'(op)), 1'b1, 7'(op),
            ref_word(7'(op), 1'b1), ref_word(7'(op), 1'b0));
      check_bit($sformatf("mutex_rw_en_%b", 7'(op)), mem_read1 & mem_write1, 1'b0);
      check_bit($sformatf("mutex_rw_dis_%b", 7'(op)), mem_read0 & mem_write0, 1'b0);
      check_bit($sformatf("m2r_en_%b", 7'(op)), mem_to_reg1 & ~mem_read1, 1'b0);
      check_bit($sformatf("m2r_dis_%b", 7'(op)), mem_to_reg0 & ~mem_read0, 1'b0);
      if (illegal1 === 1'b0) legal_en++;
      if (illegal0 === 1'b0) legal_dis++;
    end
    check("legal_count/en", 9'(legal_en), 9'd5);
    check("legal_count/dis", 9'(legal_dis), 9'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder of the 64-bit RISC-V single-cycle CPU.
- Decodes the 7-bit instruction opcode into the datapath control signals: branch, memory read/write, write-back select, ALU operation class, ALU operand select and register write.
- Outputs are registered: one clock of latency, synchronous active-low reset.
- Also flags unsupported opcodes so the pipeline or top level can trap or ignore them.

Parameters:
- ENABLE_ITYPE, default 1: when 1, I-type ALU opcode 0010011 is decoded; when 0 it is treated as illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- opcode  input  7  instruction bits [6:0].
- branch  output  1  conditional branch instruction.
- mem_read  output  1  data memory read enable.
- mem_to_reg  output  1  write-back source: 1 = memory data, 0 = ALU result.
- alu_op  output  2  ALU operation class for the ALU control unit.
- mem_write  output  1  data memory write enable.
- alu_src  output  1  ALU operand B: 1 = immediate, 0 = rs2.
- reg_write  output  1  register file write enable.
- illegal  output  1  opcode is not supported.

Behaviour:
- Decode is purely combinational from opcode; every output is a flop loaded at each rising clk edge.
  - Latency: the value presented on opcode before edge N appears on the outputs after edge N.
  - Outputs hold between edges.
- Reset:
  - If rst_n = 0 at a rising edge, all outputs become 0, including illegal, regardless of opcode.
  - Reset has priority over decode.
  - An asynchronous drop of rst_n has no effect until the next edge.
  - After release, the first edge with rst_n = 1 loads the decoded values.
- Decode table (branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write, illegal):
  - 0000011 load (LD): 0,1,1,00,0,1,1,0
  - 0100011 store (SD): 0,0,0,00,1,1,0,0
  - 1100011 branch (BEQ): 1,0,0,01,0,0,0,0
  - 0110011 R-type (ADD/SUB/MUL/AND/OR…): 0,0,0,10,0,0,1,0
  - 0010011 I-type ALU (only when ENABLE_ITYPE=1): 0,0,0,11,0,1,1,0
  - Any other value, including 0010011 when ENABLE_ITYPE=0 and every opcode whose bits [1:0] are not 11: 0,0,0,00,0,0,0,1
- Safe default: an illegal opcode must never assert mem_write, reg_write, mem_read or branch.
- Decode is a full-case match on all 7 bits; there are no partial matches, no don't-care bits and no latches.
- X or Z on opcode is not required to propagate; the default (illegal) row is acceptable.
- Consecutive different opcodes on successive edges produce the corresponding rows on successive cycles with no bubbles.
- Mutual exclusion, which must hold in every state: mem_read and mem_write are never both 1; mem_to_reg = 1 only when mem_read = 1.

Test Plan:
- Reset: hold rst_n = 0 with opcode = 0000011 for 2 edges -> all outputs 0. Release and apply one edge -> 0,1,1,00,0,1,1,0.
- Sweep the supported opcodes 0000011, 0100011, 1100011, 0110011, 0010011 on consecutive edges -> each row exactly as in the decode table, one cycle after its opcode is applied.
- Illegal opcodes 1111111, 0000000, 0110111 -> branch = 0, mem_read = 0, mem_to_reg = 0, alu_op = 00, mem_write = 0, alu_src = 0, reg_write = 0, illegal = 1.
- ENABLE_ITYPE = 0, opcode = 0010011 -> all zeros with illegal = 1. With ENABLE_ITYPE = 1 -> 0,0,0,11,0,1,1,0.
- Mid-stream reset: apply 0100011, assert rst_n = 0 for one edge, then resume with 0110011 -> mem_write drops to 0 at the reset edge, and the next edge gives R-type values (reg_write = 1, alu_op = 10).
- Exhaustive check of all 128 opcodes -> mutual-exclusion invariants hold; exactly the 5 listed opcodes (or 4 with ENABLE_ITYPE = 0) give illegal = 0.
